// File: rtl/esc_pkg.sv
// esc_pkg: shared constants, types and helpers for the multi-channel ESC generator.
//   US_PER_TICK        : microseconds per timer tick (1 MHz timer)
//   DEF_*              : default frame length, minimum pulse and command timeout
//   tmr_state_e        : frame timer run state (waiting for first edge / running)
//   width_sat()        : pulse width in ticks, saturated so each frame keeps a low cycle
package esc_pkg;

    localparam int unsigned US_PER_TICK        = 1;
    localparam int unsigned DEF_PERIOD_US      = 2500;
    localparam int unsigned DEF_MIN_US         = 1000;
    localparam int unsigned DEF_TIMEOUT_FRAMES = 50;

    typedef enum logic {
        StIdle,
        StRun
    } tmr_state_e;

    // Width in ticks for a throttle value; capped at period-1 so sig always returns low.
    function automatic int unsigned width_sat(input int unsigned min_us,
                                              input int unsigned v,
                                              input int unsigned period);
        int unsigned sum;
        sum = (min_us + v) / US_PER_TICK;
        if (sum > period - 1) begin
            return period - 1;
        end
        return sum;
    endfunction

endpackage

// File: rtl/esc_multi_if.sv
// esc_multi_if: throttle command / pulse output bundle of esc_multi.
//   val      : packed throttle values, channel i at [i*VW +: VW]
//   wr_en    : per-channel write strobe
//   arm      : 1 passes commanded throttle, 0 forces idle pulses
//   sig      : per-channel ESC pulse outputs
//   frame    : one-cycle strobe on the first cycle of each frame
//   failsafe : command timeout active
interface esc_multi_if #(
    parameter int unsigned CH = 4,
    parameter int unsigned VW = 10
);
    logic [CH*VW-1:0] val;
    logic [CH-1:0]    wr_en;
    logic             arm;
    logic [CH-1:0]    sig;
    logic             frame;
    logic             failsafe;

    modport master (
        output val, wr_en, arm,
        input  sig, frame, failsafe
    );

    modport slave (
        input  val, wr_en, arm,
        output sig, frame, failsafe
    );
endinterface

// File: rtl/esc_frame_timer.sv
// esc_frame_timer: frame counter, frame strobe and command-timeout failsafe.
//   clk           : 1 MHz timer clock
//   rst           : asynchronous active-low reset
//   wr_any        : any channel written this edge (clears the timeout)
//   boundary      : the coming edge starts a new frame (combinational)
//   cnt_next      : frame counter value after the coming edge (combinational)
//   failsafe_next : failsafe value after the coming edge (combinational)
//   frame         : registered strobe, high while cnt == 0
//   failsafe      : registered timeout flag
module esc_frame_timer
    import esc_pkg::*;
#(
    parameter int unsigned PERIOD_US      = DEF_PERIOD_US,
    parameter int unsigned TIMEOUT_FRAMES = DEF_TIMEOUT_FRAMES,
    parameter int unsigned CW             = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_any,
    output logic          boundary,
    output logic [CW-1:0] cnt_next,
    output logic          failsafe_next,
    output logic          frame,
    output logic          failsafe
);

    localparam int unsigned TW = (TIMEOUT_FRAMES > 0) ? $clog2(TIMEOUT_FRAMES + 1) : 1;

    tmr_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q;
    logic [TW-1:0] to_cnt_q, to_cnt_d;

    // Idle only exists between reset release and the first edge, which opens frame 0.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  state_d = StRun;
            StRun:   state_d = StRun;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        boundary      = (state_q == StIdle) || (cnt_q == CW'(PERIOD_US - 1));
        cnt_next      = boundary ? '0 : cnt_q + 1'b1;
        to_cnt_d      = to_cnt_q;
        failsafe_next = failsafe;
        if (wr_any) begin
            to_cnt_d      = '0;
            failsafe_next = 1'b0;
        end else if (boundary && (to_cnt_q < TW'(TIMEOUT_FRAMES))) begin
            to_cnt_d = to_cnt_q + 1'b1;
        end
        // Saturated count keeps failsafe asserted until the next write.
        if (to_cnt_d == TW'(TIMEOUT_FRAMES)) begin
            failsafe_next = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            to_cnt_q <= '0;
            frame    <= 1'b0;
            failsafe <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_next;
            to_cnt_q <= to_cnt_d;
            frame    <= boundary;
            failsafe <= failsafe_next;
        end
    end

endmodule

// File: rtl/esc_multi.sv
// esc_multi: CH-channel servo-style ESC pulse generator on a 1 MHz timer.
//   tmr_1Mhz : timer clock, all state on its rising edge
//   rst      : asynchronous active-low reset
//   bus      : esc_multi_if slave (val, wr_en, arm in; sig, frame, failsafe out)
// Writes land in pending registers; at each frame boundary pending (or a write on that
// same edge) moves to shadow and the per-channel width is frozen for the whole frame.
module esc_multi
    import esc_pkg::*;
#(
    parameter int unsigned CH             = 4,
    parameter int unsigned VW             = 10,
    parameter int unsigned PERIOD_US      = DEF_PERIOD_US,
    parameter int unsigned MIN_US         = DEF_MIN_US,
    parameter int unsigned TIMEOUT_FRAMES = DEF_TIMEOUT_FRAMES
) (
    input logic        tmr_1Mhz,
    input logic        rst,
    esc_multi_if.slave bus
);

    localparam int unsigned CW = (PERIOD_US > 1) ? $clog2(PERIOD_US) : 1;

    if (MIN_US >= PERIOD_US) begin : g_chk_min
        $error("esc_multi: MIN_US must be smaller than PERIOD_US");
    end
    if (CH < 1) begin : g_chk_ch
        $error("esc_multi: CH must be at least 1");
    end
    if (VW < 1) begin : g_chk_vw
        $error("esc_multi: VW must be at least 1");
    end

    logic          boundary;
    logic [CW-1:0] cnt_next;
    logic          failsafe_next;
    logic          frame;
    logic          failsafe;
    logic          wr_any;
    logic          armed_q, armed_d;
    logic [CH-1:0] sig_q, sig_d;

    assign wr_any = |bus.wr_en;

    esc_frame_timer #(
        .PERIOD_US      (PERIOD_US),
        .TIMEOUT_FRAMES (TIMEOUT_FRAMES),
        .CW             (CW)
    ) u_timer (
        .clk           (tmr_1Mhz),
        .rst           (rst),
        .wr_any        (wr_any),
        .boundary      (boundary),
        .cnt_next      (cnt_next),
        .failsafe_next (failsafe_next),
        .frame         (frame),
        .failsafe      (failsafe)
    );

    assign armed_d = boundary ? bus.arm : armed_q;

    always_ff @(posedge tmr_1Mhz or negedge rst) begin
        if (!rst) begin
            armed_q <= 1'b0;
            sig_q   <= '0;
        end else begin
            armed_q <= armed_d;
            sig_q   <= sig_d;
        end
    end

    for (genvar i = 0; i < CH; i++) begin : g_ch
        logic [VW-1:0] slice;
        logic [VW-1:0] pending_q;
        logic [VW-1:0] shadow_q, shadow_d;
        logic [CW-1:0] width_q, width_d;

        assign slice = bus.val[i*VW +: VW];

        // Width is recomputed only at the boundary, so mid-frame arm, val or failsafe
        // changes cannot stretch or cut the pulse already running.
        always_comb begin
            shadow_d = shadow_q;
            width_d  = width_q;
            if (boundary) begin
                shadow_d = bus.wr_en[i] ? slice : pending_q;
                if (armed_d && !failsafe_next) begin
                    width_d = CW'(width_sat(MIN_US, 32'(shadow_d), PERIOD_US));
                end else begin
                    width_d = CW'(width_sat(MIN_US, 0, PERIOD_US));
                end
            end
        end

        // Registered compare against the next count: high for cnt 0..width-1.
        assign sig_d[i] = (cnt_next < width_d);

        always_ff @(posedge tmr_1Mhz or negedge rst) begin
            if (!rst) begin
                pending_q <= '0;
                shadow_q  <= '0;
                width_q   <= CW'(MIN_US);
            end else begin
                if (bus.wr_en[i]) begin
                    pending_q <= slice;
                end
                shadow_q <= shadow_d;
                width_q  <= width_d;
            end
        end
    end

    assign bus.sig      = sig_q;
    assign bus.frame    = frame;
    assign bus.failsafe = failsafe;

endmodule

// File: tb/tb_esc_multi.sv
// tb_esc_multi: table-driven frame-by-frame check of esc_multi plus a reset-mid-pulse
// sequence. Timeout is shortened to 8 frames to keep the run short.
module tb_esc_multi;
    import esc_pkg::*;

    localparam int unsigned CH     = 4;
    localparam int unsigned VW     = 10;
    localparam int unsigned PERIOD = 2500;
    localparam int unsigned MINW   = 1000;
    localparam int unsigned TMO    = 8;

    typedef struct {
        logic [CH-1:0]    wr;
        logic [CH*VW-1:0] v;
        logic             arm_v;
        int               at;      // frame cycle on which to drive; -1 = none
        int               w [CH];  // expected high cycles in this frame
        logic             fs;      // expected failsafe on the last cycle of the frame
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_err = 0;
    vec_t tbl[$];

    esc_multi_if #(.CH(CH), .VW(VW)) bus ();

    esc_multi #(
        .CH             (CH),
        .VW             (VW),
        .PERIOD_US      (PERIOD),
        .MIN_US         (MINW),
        .TIMEOUT_FRAMES (TMO)
    ) dut (
        .tmr_1Mhz (clk),
        .rst      (rst),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #(10 * 100000);
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [CH*VW-1:0] pv(input int c, input int x);
        logic [CH*VW-1:0] r;
        r = '0;
        r[c*VW +: VW] = VW'(x);
        return r;
    endfunction

    function automatic vec_t mk(input logic [CH-1:0] wr, input logic [CH*VW-1:0] v,
                                input logic a, input int at, input int w0, input int w1,
                                input int w2, input int w3, input logic fs);
        vec_t t;
        t.wr = wr;
        t.v = v;
        t.arm_v = a;
        t.at = at;
        t.w[0] = w0;
        t.w[1] = w1;
        t.w[2] = w2;
        t.w[3] = w3;
        t.fs = fs;
        return t;
    endfunction

    // Find the next frame strobe, then observe one full frame while driving the entry.
    task automatic frame_pass(input vec_t t, input bit strict, input int id);
        int            n;
        int            frame_bad;
        int            hi [CH];
        int            gap [CH];
        logic [CH-1:0] seen_low;
        logic          fs_end;
        n = 0;
        frame_bad = 0;
        seen_low = '0;
        fs_end = 1'b0;
        for (int c = 0; c < int'(CH); c++) begin
            hi[c] = 0;
            gap[c] = 0;
        end
        do begin
            @(negedge clk);
            bus.wr_en = '0;
            n++;
        end while (bus.frame !== 1'b1 && n < int'(PERIOD) + 5);
        if (bus.frame !== 1'b1) begin
            chk($sformatf("v%0d_frame_found", id), 0, 1);
            return;
        end
        if (strict) chk($sformatf("v%0d_frame_spacing", id), n, 1);
        for (int k = 0; k < int'(PERIOD); k++) begin
            if (k > 0) begin
                @(negedge clk);
                bus.wr_en = '0;
            end
            if (bus.frame !== (k == 0)) frame_bad++;
            for (int c = 0; c < int'(CH); c++) begin
                if (bus.sig[c] === 1'b1) begin
                    if (seen_low[c]) gap[c]++;
                    hi[c]++;
                end else begin
                    seen_low[c] = 1'b1;
                end
            end
            if (k == int'(PERIOD) - 1) fs_end = bus.failsafe;
            if (k == t.at) begin
                bus.arm = t.arm_v;
                if (t.wr != '0) begin
                    bus.val = t.v;
                    bus.wr_en = t.wr;
                end
            end
        end
        chk($sformatf("v%0d_frame_strobe_errs", id), frame_bad, 0);
        for (int c = 0; c < int'(CH); c++) begin
            chk($sformatf("v%0d_width_ch%0d", id, c), hi[c], t.w[c]);
            chk($sformatf("v%0d_contig_ch%0d", id, c), gap[c], 0);
        end
        chk($sformatf("v%0d_failsafe", id), int'(fs_end), int'(t.fs));
    endtask

    initial begin
        int n;
        bus.val = '0;
        bus.wr_en = '0;
        bus.arm = 1'b1;

        // Reset and idle
        repeat (5) @(negedge clk);
        chk("rst_sig", int'(bus.sig), 0);
        chk("rst_frame", int'(bus.frame), 0);
        chk("rst_failsafe", int'(bus.failsafe), 1);
        rst = 1'b1;

        tbl.push_back(mk(4'b0000, '0, 1'b1, -1, 1000, 1000, 1000, 1000, 1'b1));
        // Full scale written mid-frame: applies next frame, clears failsafe now
        tbl.push_back(mk(4'b0011, pv(0, 1023) | pv(1, 0), 1'b1, 1,
                         1000, 1000, 1000, 1000, 1'b0));
        // Boundary write of ch2 on the last cycle's edge
        tbl.push_back(mk(4'b0100, pv(2, 512), 1'b1, int'(PERIOD) - 1,
                         2023, 1000, 1000, 1000, 1'b0));
        tbl.push_back(mk(4'b1000, pv(3, 12), 1'b1, 200, 2023, 1000, 1512, 1000, 1'b0));
        // Arm gating
        tbl.push_back(mk(4'b0000, '0, 1'b0, 300, 2023, 1000, 1512, 1012, 1'b0));
        tbl.push_back(mk(4'b0000, '0, 1'b0, -1, 1000, 1000, 1000, 1000, 1'b0));
        tbl.push_back(mk(4'b0000, '0, 1'b1, 400, 1000, 1000, 1000, 1000, 1'b0));
        tbl.push_back(mk(4'b0000, '0, 1'b1, -1, 2023, 1000, 1512, 1012, 1'b0));
        // Timeout: last write, then TMO silent boundaries
        tbl.push_back(mk(4'b0001, pv(0, 12), 1'b1, 50, 2023, 1000, 1512, 1012, 1'b0));
        for (int i = 1; i < int'(TMO); i++) begin
            tbl.push_back(mk(4'b0000, '0, 1'b1, -1, 1012, 1000, 1512, 1012, 1'b0));
        end
        tbl.push_back(mk(4'b0000, '0, 1'b1, -1, 1000, 1000, 1000, 1000, 1'b1));
        tbl.push_back(mk(4'b0010, pv(1, 5), 1'b1, 700, 1000, 1000, 1000, 1000, 1'b0));
        // Restore, then load full scale on ch0 for the reset-mid-pulse sequence
        tbl.push_back(mk(4'b0001, pv(0, 1023), 1'b1, int'(PERIOD) - 1,
                         1012, 1005, 1512, 1012, 1'b0));

        for (int i = 0; i < tbl.size(); i++) begin
            frame_pass(tbl[i], i > 0, i);
        end

        // Reset 300 cycles into a 2023-cycle pulse
        n = 0;
        do begin
            @(negedge clk);
            bus.wr_en = '0;
            n++;
        end while (bus.frame !== 1'b1 && n < int'(PERIOD) + 5);
        chk("r6_frame_found", int'(bus.frame === 1'b1), 1);
        repeat (300) @(negedge clk);
        chk("r6_sig0_before", int'(bus.sig[0]), 1);
        #2 rst = 1'b0;
        #1;
        chk("r6_sig_async", int'(bus.sig), 0);
        chk("r6_frame_async", int'(bus.frame), 0);
        chk("r6_failsafe_async", int'(bus.failsafe), 1);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        frame_pass(mk(4'b0000, '0, 1'b1, -1, 1000, 1000, 1000, 1000, 1'b1), 1'b1, 99);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
